mem_trig_capture: RTL and testbench
===================================

// Module: mem_trig_capture
//
// PURPOSE
//   Downstream stage of the memory-write trigger monitor. Takes per-memory write-hit pulses
//   and the sampled memory word, timestamps them and buffers them in a FIFO.
//   Drains them over a valid/ready stream to the host-side transactor, so hits are not lost
//   when the consumer stalls. Channel i is armed only while addr_len > i, matching getConfig.
//
// PARAMETERS
//   NCH     3    number of monitored memories (hit channels), 1..8
//   DWIDTH  32   captured data width
//   TSW     32   timestamp counter width
//   DEPTH   16   FIFO entries, power of two, >= 2
//   CHW     $clog2(NCH) (min 1), channel-id width (localparam)
//
// PORTS
//   clk        in   1            clock (same clock as the monitored memories)
//   rst_n      in   1            asynchronous reset, active low
//   addr_len   in   8            number of armed channels; channel i armed iff addr_len > i
//   hit        in   NCH          per-channel write-hit pulse, sampled each posedge
//   hit_data   in   NCH*DWIDTH   data for channel i at [i*DWIDTH +: DWIDTH], valid with hit[i]
//   out_valid  out  1            FIFO head entry valid
//   out_ready  in   1            consumer accepts head when out_valid && out_ready
//   out_ch     out  CHW          channel id of head entry
//   out_data   out  DWIDTH       data of head entry
//   out_ts     out  TSW          timestamp of head entry (ts counter value in the hit cycle)
//   level      out  $clog2(DEPTH)+1  current FIFO occupancy
//   ovf        out  NCH          sticky per-channel drop flag
//   drop_cnt   out  16           total dropped hits, saturates at 16'hFFFF
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): ts=0, all pending slots empty, FIFO empty, out_valid=0,
//     out_ch/out_data/out_ts=0, level=0, ovf=0, drop_cnt=0. Takes effect mid-operation
//     with no exceptions; in-flight entries are discarded.
//   - ts: free-running TSW-bit counter, +1 every cycle, wraps to 0 with no flag.
//   - Capture: hit[i] && armed(i) at edge N -> pending[i] <= {data, ts}.
//     A hit on an unarmed channel is ignored and is not counted as a drop.
//   - Arbiter: each cycle, lowest-index full pending slot is written to the FIFO if it is
//     not full. One write per cycle max. The slot empties on that edge.
//   - Same channel drained and re-hit in one cycle: the new hit is loaded, no drop.
//   - Hit on a channel whose pending slot stays full this cycle: hit dropped, ovf[i] <= 1,
//     drop_cnt += 1 (saturating). Multiple drops in one cycle add their count, saturating.
//   - FIFO full: pending slots hold (backpressure), no overwrite of FIFO contents.
//   - Minimum latency: hit at edge N -> pending at N -> FIFO write at N+1 -> out_valid
//     high after edge N+1 (visible in cycle N+2). Head registers are stable while
//     out_valid && !out_ready.
//   - FIFO: push and pop in the same cycle when full or empty-with-push are both legal.
//     Full+pop+push: level unchanged. Empty: out_valid=0 and head fields hold last value.
//   - Pointers: log2(DEPTH)+1 bits. Wrap-around is by natural overflow.
//     full = MSBs differ and low bits equal.
//   - addr_len lowered while a slot is pending: the entry still drains. Only new hits
//     are gated.
//   - ovf is cleared only by reset.
//
// STRUCTURE
//   - trig_pkg: NCH/DWIDTH/TSW defaults.
//     typedef struct packed {logic [CHW-1:0] ch; logic [TSW-1:0] ts; logic [DWIDTH-1:0] data;}
//     trig_entry_t. Also the saturating-add function sat_add16.
//   - Sub-module trig_sync_fifo: a DEPTH x trig_entry_t synchronous FIFO with registered
//     head and a level output. The top level holds the ts counter, pending slots, arbiter
//     and drop logic.
//
// TESTING
//   1. Reset then addr_len=3, hit=3'b001, data0=32'hA5A5_0001 at ts=5 -> out_valid two
//      cycles later; ch=0, data=A5A5_0001, ts=5, level=1.
//   2. hit=3'b111 in one cycle, out_ready=1 -> three entries out, ordered ch0,ch1,ch2, all
//      with the same ts. No drops.
//   3. addr_len=1, hit=3'b110 -> nothing captured, ovf=0, drop_cnt=0.
//   4. out_ready=0, ch0 hit every cycle for DEPTH+3 cycles -> FIFO fills with DEPTH entries.
//      Pending holds 1, then 2 drops: ovf[0]=1, drop_cnt=2. Release ready -> DEPTH+1 entries
//      out, in order.
//   5. Preload ts near wrap (TSW=8 build). A hit at ts=8'hFF and the next at ts=8'h00 are
//      both reported with exact values.
//   6. Assert rst_n low mid-burst with level=5 -> out_valid=0, level=0, drop_cnt=0
//      immediately (async). Normal capture resumes after release.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared defaults, entry layout and helpers for the memory-write trigger capture stage.
package trig_pkg;

   localparam int NCH_DEF    = 3;
   localparam int DWIDTH_DEF = 32;
   localparam int TSW_DEF    = 32;
   localparam int DEPTH_DEF  = 16;
   localparam int CHW_DEF    = (NCH_DEF > 1) ? $clog2(NCH_DEF) : 1;

   // One captured hit: originating channel, timestamp of the hit cycle, sampled word.
   typedef struct packed {
      logic [CHW_DEF-1:0]    ch;
      logic [TSW_DEF-1:0]    ts;
      logic [DWIDTH_DEF-1:0] data;
   } trig_entry_t;

   // 16-bit add that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/trig_sync_fifo.sv
// Synchronous FIFO with a registered head entry and an occupancy output.
// Handshake: a write is taken when wr_valid_i && wr_ready_o; the head is
// consumed when rd_valid_o && rd_ready_i. A full FIFO still accepts a write
// in a cycle where its head is being consumed.
module trig_sync_fifo
   import trig_pkg::*;
#(
   parameter type      entry_t = trig_entry_t,
   parameter int       DEPTH   = DEPTH_DEF,
   localparam int      AW      = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_valid_i,
   output logic        wr_ready_o,
   input  entry_t      wr_data_i,
   output logic        rd_valid_o,
   input  logic        rd_ready_i,
   output entry_t      rd_data_o,
   output logic [AW:0] level_o
);

   entry_t      mem_q [DEPTH];
   entry_t      head_q, head_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        empty, full, push, pop;

   // Extra pointer MSB separates full from empty when the low bits match.
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = !empty && rd_ready_i;
   assign wr_ready_o = !full || pop;
   assign push       = wr_valid_i && wr_ready_o;

   assign rd_valid_o = !empty;
   assign rd_data_o  = head_q;
   assign level_o    = wr_ptr_q - rd_ptr_q;

   // Next pointers and next head; a write into an (effectively) empty FIFO bypasses to the head.
   always_comb begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      head_d   = head_q;
      if (wr_ptr_d != rd_ptr_d) begin
         if (rd_ptr_d == wr_ptr_q) head_d = wr_data_i;
         else                      head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
   end

   // Storage array; contents need no reset since the pointers qualify them.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   // Pointer and head registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/mem_trig_capture.sv
// Timestamps per-memory write hits, parks each in a one-deep pending slot and
// moves them (lowest channel first) into a FIFO drained over a valid/ready stream.
// Stream handshake: the head entry transfers on a cycle with out_valid && out_ready;
// head fields stay stable while out_valid && !out_ready.
module mem_trig_capture
   import trig_pkg::*;
#(
   parameter int  NCH    = NCH_DEF,
   parameter int  DWIDTH = DWIDTH_DEF,
   parameter int  TSW    = TSW_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int LW     = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            addr_len,
   input  logic [NCH-1:0]        hit,
   input  logic [NCH*DWIDTH-1:0] hit_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CHW-1:0]        out_ch,
   output logic [DWIDTH-1:0]     out_data,
   output logic [TSW-1:0]        out_ts,
   output logic [LW-1:0]         level,
   output logic [NCH-1:0]        ovf,
   output logic [15:0]           drop_cnt
);

   typedef struct packed {
      logic [CHW-1:0]    ch;
      logic [TSW-1:0]    ts;
      logic [DWIDTH-1:0] data;
   } entry_t;

   typedef struct packed {
      logic [TSW-1:0]    ts;
      logic [DWIDTH-1:0] data;
   } slot_t;

   logic [TSW-1:0] ts_q;
   logic [NCH-1:0] pend_v_q, pend_v_d;
   slot_t          pend_q [NCH];
   slot_t          pend_d [NCH];
   logic [NCH-1:0] ovf_q, ovf_d;
   logic [15:0]    drop_q, drop_d;
   logic [NCH-1:0] gnt;
   logic           wr_valid, wr_ready;
   entry_t         wr_entry, head;

   // Free-running timestamp, wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_q + TSW'(1);
   end

   // Fixed-priority pick of the lowest-index occupied slot as the FIFO write candidate.
   always_comb begin
      gnt      = '0;
      wr_valid = 1'b0;
      wr_entry = '0;
      for (int i = 0; i < NCH; i++) begin
         if (pend_v_q[i] && !wr_valid) begin
            wr_valid      = 1'b1;
            gnt[i]        = 1'b1;
            wr_entry.ch   = CHW'(i);
            wr_entry.ts   = pend_q[i].ts;
            wr_entry.data = pend_q[i].data;
         end
      end
   end

   // Slot update: drain frees the slot first so a same-cycle re-hit loads instead of dropping.
   always_comb begin
      logic [15:0] n_drop;
      pend_v_d = pend_v_q;
      pend_d   = pend_q;
      ovf_d    = ovf_q;
      n_drop   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt[i] && wr_ready) pend_v_d[i] = 1'b0;
         if (hit[i] && (addr_len > 8'(i))) begin
            if (!pend_v_d[i]) begin
               pend_v_d[i]    = 1'b1;
               pend_d[i].ts   = ts_q;
               pend_d[i].data = hit_data[i*DWIDTH +: DWIDTH];
            end else begin
               ovf_d[i] = 1'b1;
               n_drop   = n_drop + 16'd1;
            end
         end
      end
      drop_d = sat_add16(drop_q, n_drop);
   end

   // Pending slots, sticky overflow flags and the drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v_q <= '0;
         for (int i = 0; i < NCH; i++) pend_q[i] <= '0;
         ovf_q    <= '0;
         drop_q   <= '0;
      end else begin
         pend_v_q <= pend_v_d;
         for (int i = 0; i < NCH; i++) pend_q[i] <= pend_d[i];
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   trig_sync_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid_i (wr_valid),
      .wr_ready_o (wr_ready),
      .wr_data_i  (wr_entry),
      .rd_valid_o (out_valid),
      .rd_ready_i (out_ready),
      .rd_data_o  (head),
      .level_o    (level)
   );

   assign out_ch   = head.ch;
   assign out_ts   = head.ts;
   assign out_data = head.data;
   assign ovf      = ovf_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mem_trig_capture.sv
// Bench for mem_trig_capture (8-bit timestamp build so the wrap is reachable).
module tb_mem_trig_capture;

   localparam int NCH   = 3;
   localparam int DW    = 32;
   localparam int TSW   = 8;
   localparam int DEPTH = 16;
   localparam int CHW   = 2;
   localparam int LW    = 5;
   localparam int EW    = CHW + TSW + DW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        addr_len = 8'd0;
   logic [NCH-1:0]    hit = '0;
   logic [NCH*DW-1:0] hit_data = '0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [CHW-1:0]    out_ch;
   logic [DW-1:0]     out_data;
   logic [TSW-1:0]    out_ts;
   logic [LW-1:0]     level;
   logic [NCH-1:0]    ovf;
   logic [15:0]       drop_cnt;

   // clock / reset
   always #5 clk = ~clk;

   mem_trig_capture #(.NCH(NCH), .DWIDTH(DW), .TSW(TSW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr_len  (addr_len),
      .hit       (hit),
      .hit_data  (hit_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .out_ts    (out_ts),
      .level     (level),
      .ovf       (ovf),
      .drop_cnt  (drop_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [EW-1:0] m_q [$];
   logic [EW-1:0] m_slot [NCH];
   bit            m_full [NCH];
   logic [NCH-1:0] m_ovf;
   int            m_drops;
   int            m_ts;
   logic [EW-1:0] m_head;
   logic [EW-1:0] pop_log [$];

   function automatic void model_reset();
      m_q.delete();
      for (int i = 0; i < NCH; i++) begin
         m_full[i] = 0;
         m_slot[i] = '0;
      end
      m_ovf   = '0;
      m_drops = 0;
      m_ts    = 0;
      m_head  = '0;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            for (int i = 0; i < NCH; i++) begin
               if (m_full[i]) begin
                  if (m_q.size() < DEPTH) begin
                     m_q.push_back(m_slot[i]);
                     m_full[i] = 0;
                  end
                  break;
               end
            end
            for (int i = 0; i < NCH; i++) begin
               if (hit[i] && (int'(addr_len) > i)) begin
                  if (m_full[i]) begin
                     m_ovf[i] = 1'b1;
                     m_drops++;
                  end else begin
                     m_full[i] = 1;
                     m_slot[i] = {CHW'(i), TSW'(m_ts), hit_data[i*DW +: DW]};
                  end
               end
            end
            m_ts = (m_ts + 1) % 256;
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (m_q.size() > 0) m_head = m_q[0];
         chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
         chk("level", 64'(level), 64'(m_q.size()));
         chk("head", 64'({out_ch, out_ts, out_data}), 64'(m_head));
         chk("ovf", 64'(ovf), 64'(m_ovf));
         chk("drop_cnt", 64'(drop_cnt), 64'((m_drops > 65535) ? 65535 : m_drops));
         if (out_valid && out_ready) pop_log.push_back({out_ch, out_ts, out_data});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_hit(input logic [NCH-1:0] h, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2);
      hit      = h;
      hit_data = {d2, d1, d0};
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int t_hit;
      int k;
      logic [EW-1:0] e;

      addr_len = 8'd3;
      step(2);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_head", 64'({out_ch, out_ts, out_data}), 64'd0);
      rst_n = 1'b1;

      // T1: single hit on ch0 at ts=5
      step(5);
      chk("t1_model_ts", 64'(m_ts), 64'd5);
      set_hit(3'b001, 32'hA5A5_0001, 32'h0, 32'h0);
      step(1);
      hit = '0;
      chk("t1_not_yet", 64'(out_valid), 64'd0);
      step(1);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_ch", 64'(out_ch), 64'd0);
      chk("t1_data", 64'(out_data), 64'hA5A5_0001);
      chk("t1_ts", 64'(out_ts), 64'd5);
      chk("t1_level", 64'(level), 64'd1);
      out_ready = 1'b1;
      step(2);
      chk("t1_drained", 64'(level), 64'd0);

      // T2: all three channels in one cycle
      pop_log.delete();
      t_hit = m_ts;
      set_hit(3'b111, 32'h11, 32'h22, 32'h33);
      step(1);
      hit = '0;
      step(6);
      chk("t2_count", 64'(pop_log.size()), 64'd3);
      if (pop_log.size() == 3) begin
         e = {2'd0, 8'(t_hit), 32'h11}; chk("t2_e0", 64'(pop_log[0]), 64'(e));
         e = {2'd1, 8'(t_hit), 32'h22}; chk("t2_e1", 64'(pop_log[1]), 64'(e));
         e = {2'd2, 8'(t_hit), 32'h33}; chk("t2_e2", 64'(pop_log[2]), 64'(e));
      end
      chk("t2_drop", 64'(drop_cnt), 64'd0);

      // T3: unarmed channels are ignored
      addr_len = 8'd1;
      set_hit(3'b110, 32'h0, 32'hBAD1, 32'hBAD2);
      step(3);
      hit = '0;
      step(3);
      chk("t3_level", 64'(level), 64'd0);
      chk("t3_count", 64'(pop_log.size()), 64'd3);
      chk("t3_ovf", 64'(ovf), 64'd0);
      chk("t3_drop", 64'(drop_cnt), 64'd0);
      addr_len = 8'd3;

      // T4: fill under backpressure, two drops, then drain in order
      out_ready = 1'b0;
      pop_log.delete();
      t_hit = m_ts;
      for (int j = 1; j <= DEPTH + 3; j++) begin
         set_hit(3'b001, 32'(j), 32'h0, 32'h0);
         step(1);
      end
      hit = '0;
      step(2);
      chk("t4_level_full", 64'(level), 64'd16);
      chk("t4_ovf", 64'(ovf), 64'b001);
      chk("t4_drop", 64'(drop_cnt), 64'd2);
      out_ready = 1'b1;
      step(25);
      chk("t4_count", 64'(pop_log.size()), 64'd17);
      if (pop_log.size() == 17) begin
         for (int j = 1; j <= 17; j++) begin
            e = {2'd0, 8'(t_hit + j - 1), 32'(j)};
            chk("t4_order", 64'(pop_log[j-1]), 64'(e));
         end
      end
      chk("t4_drop_after", 64'(drop_cnt), 64'd2);

      // T5: timestamp wrap, same-channel drain and re-hit
      pop_log.delete();
      k = 0;
      while (m_ts != 255 && k < 300) begin
         step(1);
         k++;
      end
      chk("t5_reach_ff", 64'(m_ts), 64'd255);
      set_hit(3'b010, 32'h0, 32'hCAFE_0001, 32'h0);
      step(1);
      chk("t5_model_wrap", 64'(m_ts), 64'd0);
      set_hit(3'b010, 32'h0, 32'hCAFE_0002, 32'h0);
      step(1);
      hit = '0;
      step(6);
      chk("t5_count", 64'(pop_log.size()), 64'd2);
      if (pop_log.size() == 2) begin
         e = {2'd1, 8'hFF, 32'hCAFE_0001}; chk("t5_ff", 64'(pop_log[0]), 64'(e));
         e = {2'd1, 8'h00, 32'hCAFE_0002}; chk("t5_00", 64'(pop_log[1]), 64'(e));
      end
      chk("t5_drop", 64'(drop_cnt), 64'd2);

      // T6: asynchronous reset mid-burst
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         set_hit(3'b001, 32'h600 + 32'(j), 32'h0, 32'h0);
         step(1);
      end
      hit = '0;
      step(3);
      chk("t6_level5", 64'(level), 64'd5);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_level", 64'(level), 64'd0);
      chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
      chk("t6_rst_ovf", 64'(ovf), 64'd0);
      step(2);
      rst_n = 1'b1;
      set_hit(3'b100, 32'h0, 32'h0, 32'h77);
      step(1);
      hit = '0;
      step(1);
      chk("t6_resume_valid", 64'(out_valid), 64'd1);
      chk("t6_resume_ch", 64'(out_ch), 64'd2);
      chk("t6_resume_data", 64'(out_data), 64'h77);
      chk("t6_resume_ts", 64'(out_ts), 64'd0);
      out_ready = 1'b1;
      step(3);
      chk("t6_final_level", 64'(level), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
